// File: rtl/eth_rst_pkg.sv
// Shared types and default timing constants for the Ethernet reset sequencer.
package eth_rst_pkg;

    // Sequencer states; encoding is fixed so debug probes read consistent values.
    typedef enum logic [2:0] {
        WAIT_LOCK = 3'd0,
        LOCK_FILT = 3'd1,
        PHY_RST   = 3'd2,
        PHY_WAIT  = 3'd3,
        RUN       = 3'd4
    } state_t;

    // Defaults for a 125 MHz clock.
    localparam int unsigned DEF_LOCK_FILT_CYC = 1024;      // lock filter length
    localparam int unsigned DEF_PHY_RST_CYC   = 1250000;   // 10 ms PHY reset low
    localparam int unsigned DEF_PHY_WAIT_CYC  = 18750000;  // 150 ms PHY settle
    localparam int          DEF_CNT_W         = 25;        // holds max(cycles)-1

endpackage

// File: rtl/sync_2ff.sv
// Generic 1-bit two-flop synchroniser with synchronous active-high reset.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Two back-to-back flops; the first may go metastable, the second resolves it.
    always_ff @(posedge clk) begin
        // NOTE: reset is sampled on the clock edge, so it lives inside the clocked block
        // rather than in the sensitivity list.
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make both flops sample the old values,
            // which is what builds a two-stage shift rather than a single wire.
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/eth_rst_seq.sv
// Ethernet reset sequencer: filters PLL lock, times the PHY hardware reset and
// its settle window, then releases the downstream MAC/UDP synchronous reset.
module eth_rst_seq
    import eth_rst_pkg::*;
#(
    parameter int unsigned LOCK_FILT_CYC = DEF_LOCK_FILT_CYC,
    parameter int unsigned PHY_RST_CYC   = DEF_PHY_RST_CYC,
    parameter int unsigned PHY_WAIT_CYC  = DEF_PHY_WAIT_CYC,
    parameter int          CNT_W         = DEF_CNT_W
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pll_lock,
    input  logic       phy_reset_req,
    output logic       phy_rst_n,
    output logic       sys_rst,
    output logic       rst_done,
    output logic       lock_lost,
    output logic [7:0] lock_loss_cnt
);

    // Terminal counts: a state lasts N cycles, so it exits when cnt reaches N-1.
    localparam logic [CNT_W-1:0] FILT_LAST = CNT_W'(LOCK_FILT_CYC - 1);
    localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(PHY_RST_CYC - 1);
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(PHY_WAIT_CYC - 1);

    logic             lock_s;
    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             phy_rst_n_q;
    logic             sys_rst_q;
    logic             rst_done_q;
    logic             lock_lost_q;
    logic [7:0]       loss_cnt_q;

    sync_2ff u_lock_sync (
        .clk (clk),
        .rst (rst),
        .d_i (pll_lock),
        .q_o (lock_s)
    );

    // Sequencer FSM; every output is registered and moves on the same edge as the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= WAIT_LOCK;
            cnt_q       <= '0;
            phy_rst_n_q <= 1'b0;
            sys_rst_q   <= 1'b1;
            rst_done_q  <= 1'b0;
            lock_lost_q <= 1'b0;
            loss_cnt_q  <= 8'd0;
        end else if (state_q != WAIT_LOCK && !lock_s) begin
            // Lock loss outranks everything except rst, including a pending request.
            state_q     <= WAIT_LOCK;
            cnt_q       <= '0;
            phy_rst_n_q <= 1'b0;
            sys_rst_q   <= 1'b1;
            rst_done_q  <= 1'b0;
            lock_lost_q <= 1'b1;
            if (loss_cnt_q != 8'hFF) begin
                loss_cnt_q <= loss_cnt_q + 8'd1;
            end
        end else begin
            unique case (state_q)
                WAIT_LOCK: begin
                    cnt_q <= '0;
                    if (lock_s) begin
                        state_q <= LOCK_FILT;
                    end
                end
                LOCK_FILT: begin
                    // lock_s is known high here; a low would have taken the loss branch.
                    if (cnt_q == FILT_LAST) begin
                        state_q <= PHY_RST;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                PHY_RST: begin
                    if (cnt_q == RST_LAST) begin
                        state_q     <= PHY_WAIT;
                        cnt_q       <= '0;
                        phy_rst_n_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                PHY_WAIT: begin
                    if (cnt_q == WAIT_LAST) begin
                        state_q    <= RUN;
                        cnt_q      <= '0;
                        sys_rst_q  <= 1'b0;
                        rst_done_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                RUN: begin
                    cnt_q <= '0;
                    if (phy_reset_req) begin
                        state_q     <= PHY_RST;
                        phy_rst_n_q <= 1'b0;
                        sys_rst_q   <= 1'b1;
                        rst_done_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= WAIT_LOCK;
                    cnt_q       <= '0;
                    phy_rst_n_q <= 1'b0;
                    sys_rst_q   <= 1'b1;
                    rst_done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign phy_rst_n     = phy_rst_n_q;
    assign sys_rst       = sys_rst_q;
    assign rst_done      = rst_done_q;
    assign lock_lost     = lock_lost_q;
    assign lock_loss_cnt = loss_cnt_q;

endmodule

// File: tb/tb_eth_rst_seq.sv
// Self-checking bench for eth_rst_seq: randomized and directed stimulus, a
// phase/elapsed-time reference model, and a scoreboard drained by a monitor.
module tb_eth_rst_seq;

    localparam int unsigned T_FILT = 8;
    localparam int unsigned T_RST  = 20;
    localparam int unsigned T_WAIT = 30;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pll_lock = 1'b0;
    logic       phy_reset_req = 1'b0;
    logic       phy_rst_n;
    logic       sys_rst;
    logic       rst_done;
    logic       lock_lost;
    logic [7:0] lock_loss_cnt;

    int n_checks = 0;
    int n_errors = 0;

    eth_rst_seq #(
        .LOCK_FILT_CYC (T_FILT),
        .PHY_RST_CYC   (T_RST),
        .PHY_WAIT_CYC  (T_WAIT),
        .CNT_W         (25)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .pll_lock      (pll_lock),
        .phy_reset_req (phy_reset_req),
        .phy_rst_n     (phy_rst_n),
        .sys_rst       (sys_rst),
        .rst_done      (rst_done),
        .lock_lost     (lock_lost),
        .lock_loss_cnt (lock_loss_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required the bench to finish first");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Phases are tracked by entry time; a timed phase ends once its duration has elapsed.
    typedef enum int {M_IDLE, M_FILT, M_PRST, M_PWAIT, M_RUN} ph_t;

    typedef struct {
        int         cyc;
        logic [11:0] outs;   // {phy_rst_n, sys_rst, rst_done, lock_lost, lock_loss_cnt}
    } exp_t;

    exp_t sb_q[$];

    ph_t  m_ph = M_IDLE;
    int   m_cyc = 0;
    int   m_start = 0;
    int   m_nloss = 0;
    bit   m_lost = 0;
    bit   m_d1 = 0, m_d2 = 0;   // two-edge delay of pll_lock

    function automatic int dur(ph_t p);
        case (p)
            M_FILT:  return T_FILT;
            M_PRST:  return T_RST;
            M_PWAIT: return T_WAIT;
            default: return 0;
        endcase
    endfunction

    function automatic ph_t next_ph(ph_t p);
        case (p)
            M_FILT:  return M_PRST;
            M_PRST:  return M_PWAIT;
            default: return M_RUN;
        endcase
    endfunction

    function automatic void model_edge(bit l, bit r, bit rs);
        bit ls;
        m_cyc++;
        if (rs) begin
            m_ph = M_IDLE; m_d1 = 0; m_d2 = 0; m_lost = 0; m_nloss = 0;
            return;
        end
        ls   = m_d2;
        m_d2 = m_d1;
        m_d1 = l;
        if (m_ph != M_IDLE && !ls) begin
            m_ph   = M_IDLE;
            m_lost = 1;
            m_nloss = (m_nloss < 255) ? m_nloss + 1 : 255;
        end else if (m_ph == M_IDLE) begin
            if (ls) begin m_ph = M_FILT; m_start = m_cyc; end
        end else if (m_ph == M_RUN) begin
            if (r) begin m_ph = M_PRST; m_start = m_cyc; end
        end else if (m_cyc - m_start == dur(m_ph)) begin
            m_ph = next_ph(m_ph);
            m_start = m_cyc;
        end
    endfunction

    function automatic logic [11:0] model_outs();
        logic pr, sr, rd;
        pr = (m_ph == M_PWAIT) || (m_ph == M_RUN);
        sr = (m_ph != M_RUN);
        rd = (m_ph == M_RUN);
        return {pr, sr, rd, m_lost, 8'(m_nloss)};
    endfunction

    // One clock of stimulus: drive, let the edge happen, predict, settle.
    task automatic tick(input bit l, input bit r, input bit rs);
        exp_t e;
        pll_lock      = l;
        phy_reset_req = r;
        rst           = rs;
        @(posedge clk);
        model_edge(l, r, rs);
        e.cyc  = m_cyc;
        e.outs = model_outs();
        sb_q.push_back(e);
        #1;
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        while (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            check($sformatf("outs@edge%0d", e.cyc),
                  {20'd0, phy_rst_n, sys_rst, rst_done, lock_lost, lock_loss_cnt},
                  {20'd0, e.outs});
        end
    end

    task automatic run_to_run(input int budget);
        int n = 0;
        while (m_ph != M_RUN && n < budget) begin
            tick(1, 0, 0);
            n++;
        end
        check("reach_run", 32'(m_ph == M_RUN), 32'd1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int phy_rise, sys_fall, low_cnt, wait_cnt, guard;

        // 1. Power-up
        repeat (4) tick(0, 0, 1);
        check("reset_phy_rst_n", 32'(phy_rst_n), 32'd0);
        check("reset_sys_rst", 32'(sys_rst), 32'd1);
        check("reset_rst_done", 32'(rst_done), 32'd0);
        phy_rise = 0; sys_fall = 0;
        for (int k = 1; k <= 80; k++) begin
            tick(1, 0, 0);
            if (phy_rise == 0 && phy_rst_n === 1'b1) phy_rise = k;
            if (sys_fall == 0 && sys_rst === 1'b0) sys_fall = k;
        end
        check("pwrup_phy_rise_edge", 32'(phy_rise), 32'd31);
        check("pwrup_sys_fall_edge", 32'(sys_fall), 32'd61);
        check("pwrup_rst_done", 32'(rst_done), 32'd1);
        check("pwrup_lock_lost", 32'(lock_lost), 32'd0);

        // 3. Loss in RUN: one low cycle on pll_lock
        tick(0, 0, 0);
        tick(1, 0, 0);
        check("loss_not_yet_sys_rst", 32'(sys_rst), 32'd0);
        tick(1, 0, 0);
        check("loss_sys_rst", 32'(sys_rst), 32'd1);
        check("loss_phy_rst_n", 32'(phy_rst_n), 32'd0);
        check("loss_lock_lost", 32'(lock_lost), 32'd1);
        check("loss_cnt", 32'(lock_loss_cnt), 32'd1);
        run_to_run(120);

        // 4. Software PHY reset
        tick(1, 1, 0);
        low_cnt = 0; wait_cnt = 0; guard = 0;
        while (phy_rst_n === 1'b0 && guard < 100) begin low_cnt++; tick(1, 0, 0); guard++; end
        while (phy_rst_n === 1'b1 && sys_rst === 1'b1 && guard < 200) begin wait_cnt++; tick(1, 0, 0); guard++; end
        check("swreq_phy_low_cycles", 32'(low_cnt), T_RST);
        check("swreq_wait_cycles", 32'(wait_cnt), T_WAIT);
        check("swreq_rst_done", 32'(rst_done), 32'd1);
        check("swreq_lock_lost_kept", 32'(lock_lost), 32'd1);

        // 5. Request on the same edge lock_s first reads 0
        tick(0, 0, 0);
        tick(1, 0, 0);
        tick(1, 1, 0);
        check("simul_phy_rst_n", 32'(phy_rst_n), 32'd0);
        check("simul_cnt", 32'(lock_loss_cnt), 32'd2);
        tick(1, 0, 0);
        check("simul_no_filt_skip", 32'(phy_rst_n), 32'd0);
        run_to_run(120);

        // 2. Glitchy lock from a clean reset
        repeat (2) tick(0, 0, 1);
        for (int p = 0; p < 6; p++) begin
            repeat (5) tick(1, $urandom_range(0, 1), 0);
            repeat (3) tick(0, 0, 0);
        end
        check("glitch_phy_rst_n", 32'(phy_rst_n), 32'd0);
        check("glitch_cnt", 32'(lock_loss_cnt), 32'd6);

        // 6a. Reset at cycle 10 of PHY_WAIT
        guard = 0;
        while (!(m_ph == M_PWAIT && m_cyc - m_start == 10) && guard < 200) begin
            tick(1, 0, 0);
            guard++;
        end
        check("mid_wait_phy_rst_n_pre", 32'(phy_rst_n), 32'd1);
        tick(1, 0, 1);
        check("mid_wait_phy_rst_n", 32'(phy_rst_n), 32'd0);
        check("mid_wait_sys_rst", 32'(sys_rst), 32'd1);
        check("mid_wait_lock_lost", 32'(lock_lost), 32'd0);
        check("mid_wait_cnt", 32'(lock_loss_cnt), 32'd0);

        // 6b. Saturation: 300 randomized lock pulses, each reaching the filter
        for (int p = 0; p < 300; p++) begin
            repeat ($urandom_range(3, 6)) tick(1, 0, 0);
            repeat ($urandom_range(3, 5)) tick(0, 0, 0);
        end
        check("sat_cnt", 32'(lock_loss_cnt), 32'd255);

        // Random soak: mostly-stable lock, sporadic requests and resets
        for (int i = 0; i < 3000; i++) begin
            tick($urandom_range(0, 199) != 0,
                 $urandom_range(0, 39) == 0,
                 $urandom_range(0, 999) == 0);
        end

        @(negedge clk);
        @(negedge clk);
        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/eth_rst_seq.md
Name: eth_rst_seq

Overview:
- Reset sequencer directly downstream of the Ethernet PLL wrapper. It runs on the 125 MHz PLL output and consumes the PLL lock signal.
- Synchronises and filters lock, then drives the external PHY hardware reset with the datasheet low/settle timing.
- Releases the synchronous reset of the MAC/UDP logic only after the PHY has settled.
- Re-sequences automatically on any loss of lock.

Parameters:
- LOCK_FILT_CYC, 1024: consecutive synchronised-lock-high cycles required before PHY reset starts.
- PHY_RST_CYC, 1250000: cycles phy_rst_n is held low (10 ms @125 MHz).
- PHY_WAIT_CYC, 18750000: cycles after phy_rst_n release before sys_rst deasserts (150 ms @125 MHz).
- CNT_W, 25: counter width. Must hold max(cycle params)-1. All cycle parameters must be ≥1.

Ports:
- clk  in  1  125 MHz PLL output clock.
- rst  in  1  synchronous, active-high reset.
- pll_lock  in  1  PLL lock. Asynchronous to clk; may glitch.
- phy_reset_req  in  1  single-cycle request to re-run the PHY reset. Honoured only in RUN.
- phy_rst_n  out  1  PHY hardware reset, active-low.
- sys_rst  out  1  synchronous active-high reset for downstream MAC logic.
- rst_done  out  1  high only in RUN.
- lock_lost  out  1  sticky: lock dropped after filtering began.
- lock_loss_cnt  out  8  saturating count of lock-loss events.

Behaviour:
- Single clock domain: one clock (clk), with a synchronous, active-high reset (rst). All flops update on the rising edge of clk.
- pll_lock passes through a 2-FF synchroniser (reset 0). Output is lock_s, 2 cycles of latency.
- Reset values: state=WAIT_LOCK, cnt=0, phy_rst_n=0, sys_rst=1, rst_done=0, lock_lost=0, lock_loss_cnt=0, sync FFs=0.
- All outputs are registered and change on the same edge as the state.
- WAIT_LOCK:
  - phy_rst_n=0, sys_rst=1, cnt=0.
  - lock_s=1 → LOCK_FILT.
- LOCK_FILT:
  - phy_rst_n=0, sys_rst=1. cnt increments each cycle.
  - When cnt==LOCK_FILT_CYC-1 with lock_s=1 → PHY_RST, cnt=0.
  - State occupancy is exactly LOCK_FILT_CYC cycles.
- PHY_RST:
  - phy_rst_n=0, sys_rst=1.
  - When cnt==PHY_RST_CYC-1 → PHY_WAIT, cnt=0, phy_rst_n=1 on that edge.
- PHY_WAIT:
  - phy_rst_n=1, sys_rst=1.
  - When cnt==PHY_WAIT_CYC-1 → RUN, sys_rst=0, rst_done=1 on that edge.
- RUN:
  - phy_rst_n=1, sys_rst=0, rst_done=1. cnt held at 0.
  - phy_reset_req=1 → PHY_RST next edge, with phy_rst_n=0, sys_rst=1, rst_done=0.
- Lock loss:
  - Condition: lock_s=0 in LOCK_FILT, PHY_RST, PHY_WAIT or RUN.
  - Next edge: state=WAIT_LOCK, cnt=0, phy_rst_n=0, sys_rst=1, rst_done=0, lock_lost=1.
  - lock_loss_cnt increments, saturating at 255.
  - lock_lost and lock_loss_cnt clear only on rst.
- Priority, highest first: rst, lock loss, phy_reset_req, counter expiry.
- phy_reset_req is ignored outside RUN. It is level-sampled, so a request held high re-enters PHY_RST each time RUN is reached.
- Parameter value 1 gives one cycle in that state. The counter never wraps.
- rst asserted mid-sequence returns to reset values on the next edge, regardless of state.

Decomposition:
- Shared package eth_rst_pkg:
  - state enum: WAIT_LOCK=0, LOCK_FILT=1, PHY_RST=2, PHY_WAIT=3, RUN=4, 3-bit.
  - default cycle constants for 125 MHz.
- One sub-module: sync_2ff, a generic 1-bit 2-flop synchroniser with synchronous reset. It is reused by other async inputs in the design.

Test Plan:
Bench parameters: LOCK_FILT_CYC=8, PHY_RST_CYC=20, PHY_WAIT_CYC=30.
1. Power-up: rst 4 cycles, then pll_lock=1 from the first post-reset edge.
   - phy_rst_n rises 31 cycles after the first sampling edge.
   - sys_rst falls and rst_done rises at cycle 61.
   - lock_lost stays 0.
2. Glitchy lock: pll_lock pulses high 5 cycles, low 3, repeated.
   - Never reaches PHY_RST; phy_rst_n stays 0.
   - lock_loss_cnt increments once per pulse that reached LOCK_FILT.
3. Loss in RUN: after RUN, drop pll_lock for 1 cycle.
   - 3 edges later: sys_rst=1, phy_rst_n=0, lock_lost=1, lock_loss_cnt=1.
   - Full sequence repeats to RUN.
4. Software PHY reset: in RUN, pulse phy_reset_req.
   - Next edge: phy_rst_n=0 for exactly 20 cycles, then 30 cycles of PHY_WAIT, then RUN.
   - lock_lost unchanged.
5. Simultaneous events: phy_reset_req=1 on the same cycle lock_s first reads 0.
   - State goes to WAIT_LOCK, not PHY_RST. lock_loss_cnt increments.
6. Reset mid-PHY_WAIT and saturation: assert rst at cycle 10 of PHY_WAIT.
   - All outputs return to reset values; lock_loss_cnt=0.
   - Separately, 300 lock losses → lock_loss_cnt=255.
